// File: rtl/load_store_unit.sv
// Load/store sequencer: routes one access per start pulse to byte-addressable RAM or the write-only MMIO window.
// Latency: RAM 3+ cycles start->done (same-cycle ack), MMIO write 3 cycles, rejected access 2 cycles.
// Backpressure: start is ignored while busy; RAM request is held until mem_ack or the watchdog expires.
module load_store_unit #(
   parameter int                DATA_W      = 32,
   parameter logic [DATA_W-1:0] MMIO_BASE   = 'h0007_0000,
   parameter int                MMIO_ADDR_W = 13,
   parameter int                TIMEOUT     = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   op_load,
   input  logic [1:0]             size,
   input  logic                   unsigned_load,
   input  logic [DATA_W-1:0]      addr,
   input  logic [DATA_W-1:0]      wdata,
   output logic                   busy,
   output logic                   done,
   output logic [DATA_W-1:0]      rdata,
   output logic                   err_align,
   output logic                   err_timeout,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [DATA_W-1:0]      mem_addr,
   output logic [DATA_W/8-1:0]    mem_be,
   output logic [DATA_W-1:0]      mem_wdata,
   input  logic [DATA_W-1:0]      mem_rdata,
   input  logic                   mem_ack,
   output logic                   mmio_we,
   output logic [MMIO_ADDR_W-1:0] mmio_addr,
   output logic [DATA_W-1:0]      mmio_wdata
);

   localparam int BE_W  = DATA_W / 8;
   localparam int OFF_W = $clog2(BE_W);
   // A disabled watchdog still needs a legal one-bit counter
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RAM_REQ = 3'd1;
   localparam logic [2:0] S_MMIO_WR = 3'd2;
   localparam logic [2:0] S_RESP    = 3'd3;
   localparam logic [2:0] S_ERR     = 3'd4;

   logic [2:0]          state;
   logic [2:0]          state_nxt;
   logic                op_load_q;
   logic [1:0]          size_q;
   logic                unsigned_q;
   logic [DATA_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_align_q;
   logic                err_timeout_q;

   logic                misalign_in;
   logic                is_mmio_in;
   logic                to_hit;
   logic [OFF_W-1:0]    off;
   logic [OFF_W+2:0]    shift_bits;
   logic [DATA_W-1:0]   size_mask;
   logic [BE_W-1:0]     be_base;
   logic [DATA_W-1:0]   store_lane;
   logic [DATA_W-1:0]   ld_shift;
   logic                ld_sign;
   logic [DATA_W-1:0]   ld_ext;

   // Request classification on the raw inputs, used only at accept time
   always_comb begin
      misalign_in = 1'b0;
      case (size)
         2'b00:   misalign_in = 1'b0;
         2'b01:   misalign_in = addr[0];
         2'b10:   misalign_in = |addr[1:0];
         default: misalign_in = (DATA_W == 32) ? 1'b1 : |addr[2:0];
      endcase
      is_mmio_in = (addr >= MMIO_BASE);
   end

   // Watchdog fires on the last permitted wait cycle; an ack in that cycle still wins
   assign to_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

   // Lane steering, byte enables and load extension from the latched request
   always_comb begin
      off        = addr_q[OFF_W-1:0];
      shift_bits = {off, 3'b000};
      size_mask  = '1;
      be_base    = '1;
      ld_shift   = mem_rdata >> shift_bits;
      ld_sign    = ld_shift[DATA_W-1];
      case (size_q)
         2'b00: begin
            size_mask = DATA_W'(8'hFF);
            be_base   = BE_W'(1);
            ld_sign   = ld_shift[7];
         end
         2'b01: begin
            size_mask = DATA_W'(16'hFFFF);
            be_base   = BE_W'(3);
            ld_sign   = ld_shift[15];
         end
         2'b10: begin
            size_mask = DATA_W'(32'hFFFF_FFFF);
            be_base   = BE_W'(15);
            ld_sign   = ld_shift[31];
         end
         default: begin
            size_mask = '1;
            be_base   = '1;
            ld_sign   = ld_shift[DATA_W-1];
         end
      endcase
      store_lane = (wdata_q & size_mask) << shift_bits;
      ld_ext     = (ld_shift & size_mask) |
                   ((!unsigned_q && ld_sign) ? ~size_mask : '0);
   end

   // Next-state selection
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (misalign_in)
                  state_nxt = S_ERR;
               else if (is_mmio_in)
                  state_nxt = op_load ? S_ERR : S_MMIO_WR;
               else
                  state_nxt = S_RAM_REQ;
            end
         end
         S_RAM_REQ: begin
            if (mem_ack)
               state_nxt = S_RESP;
            else if (to_hit)
               state_nxt = S_ERR;
         end
         S_MMIO_WR: state_nxt = S_RESP;
         S_RESP:    state_nxt = S_IDLE;
         S_ERR:     state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // State register; reset aborts any access in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Request latch, watchdog count, result and sticky error flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_load_q     <= 1'b0;
         size_q        <= 2'b00;
         unsigned_q    <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         cnt           <= '0;
         rdata_q       <= '0;
         err_align_q   <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_load_q     <= op_load;
                  size_q        <= size;
                  unsigned_q    <= unsigned_load;
                  addr_q        <= addr;
                  wdata_q       <= wdata;
                  cnt           <= '0;
                  err_align_q   <= misalign_in;
                  err_timeout_q <= 1'b0;
                  // Rejected accesses (misaligned or MMIO read) return zero
                  if (misalign_in || (is_mmio_in && op_load))
                     rdata_q <= '0;
               end
            end
            S_RAM_REQ: begin
               if (mem_ack)
                  rdata_q <= op_load_q ? ld_ext : '0;
               else if (to_hit) begin
                  err_timeout_q <= 1'b1;
                  rdata_q       <= '0;
               end else if (TIMEOUT != 0)
                  cnt <= cnt + CNT_W'(1);
            end
            S_MMIO_WR: rdata_q <= '0;
            default: ;
         endcase
      end
   end

   assign busy        = (state != S_IDLE);
   assign done        = (state == S_RESP) || (state == S_ERR);
   assign rdata       = rdata_q;
   assign err_align   = err_align_q;
   assign err_timeout = err_timeout_q;

   // RAM bus is driven only while a request is outstanding
   assign mem_req   = (state == S_RAM_REQ);
   assign mem_we    = mem_req & ~op_load_q;
   assign mem_addr  = mem_req ? {addr_q[DATA_W-1:OFF_W], OFF_W'(0)} : '0;
   assign mem_be    = mem_req ? (be_base << off) : '0;
   assign mem_wdata = mem_req ? store_lane : '0;

   assign mmio_we    = (state == S_MMIO_WR);
   assign mmio_addr  = addr_q[MMIO_ADDR_W-1:0];
   assign mmio_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: lane steering, extension, MMIO, errors, watchdog, reset.
// Latency: checks fixed start->done cycle counts by stepping one clock at a time.
// Backpressure: exercises delayed ack, ignored start while busy, stray ack in idle.
module tb_load_store_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic        op_load;
   logic [1:0]  size;
   logic        unsigned_load;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   logic        busy, done, err_align, err_timeout, mem_req, mem_we, mmio_we;
   logic [31:0] rdata, mem_addr, mem_wdata, mmio_wdata;
   logic [3:0]  mem_be;
   logic [12:0] mmio_addr;

   logic        t_busy, t_done, t_err_align, t_err_timeout, t_mem_req, t_mem_we, t_mmio_we;
   logic [31:0] t_rdata, t_mem_addr, t_mem_wdata, t_mmio_wdata;
   logic [3:0]  t_mem_be;
   logic [12:0] t_mmio_addr;

   int n_chk;
   int n_fail;

   load_store_unit u_dut (
      .clk(clk), .rst(rst), .start(start), .op_load(op_load), .size(size),
      .unsigned_load(unsigned_load), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .rdata(rdata), .err_align(err_align),
      .err_timeout(err_timeout), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mmio_we(mmio_we),
      .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata)
   );

   // Short-watchdog instance sharing all stimulus
   load_store_unit #(.TIMEOUT(4)) u_dut_to (
      .clk(clk), .rst(rst), .start(start), .op_load(op_load), .size(size),
      .unsigned_load(unsigned_load), .addr(addr), .wdata(wdata),
      .busy(t_busy), .done(t_done), .rdata(t_rdata), .err_align(t_err_align),
      .err_timeout(t_err_timeout), .mem_req(t_mem_req), .mem_we(t_mem_we),
      .mem_addr(t_mem_addr), .mem_be(t_mem_be), .mem_wdata(t_mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mmio_we(t_mmio_we),
      .mmio_addr(t_mmio_addr), .mmio_wdata(t_mmio_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request; returns in the first cycle after acceptance
   task automatic issue(input logic ld, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
      op_load       = ld;
      size          = sz;
      unsigned_load = uns;
      addr          = a;
      wdata         = wd;
      start         = 1'b1;
      tick();
      start         = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst = 1'b0; start = 1'b0; op_load = 1'b0; size = 2'b00; unsigned_load = 1'b0;
      addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err_align", err_align, 0);
      chk("rst_err_timeout", err_timeout, 0);
      chk("rst_mmio_we", mmio_we, 0);
      chk("rst_mem_be", mem_be, 0);
      rst = 1'b1;
      tick();

      // Byte load, sign-extended, lane 3
      issue(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
      chk("ldb_busy", busy, 1);
      chk("ldb_req", mem_req, 1);
      chk("ldb_we", mem_we, 0);
      chk("ldb_addr", mem_addr, 32'h0000_0100);
      chk("ldb_be", mem_be, 4'b1000);
      chk("ldb_no_done", done, 0);
      mem_ack = 1'b1; mem_rdata = 32'h80FF_FFFF;
      tick();
      mem_ack = 1'b0;
      chk("ldb_done", done, 1);
      chk("ldb_rdata", rdata, 32'hFFFF_FF80);
      chk("ldb_err", err_align, 0);
      tick();
      chk("ldb_done_end", done, 0);
      chk("ldb_busy_end", busy, 0);
      chk("ldb_rdata_held", rdata, 32'hFFFF_FF80);

      // MMIO load is rejected without error flags and returns zero
      issue(1'b1, 2'b10, 1'b0, 32'h0007_0000, 32'h0);
      chk("mmld_req", mem_req, 0);
      chk("mmld_done", done, 1);
      chk("mmld_rdata", rdata, 0);
      chk("mmld_err_align", err_align, 0);
      chk("mmld_err_timeout", err_timeout, 0);
      chk("mmld_mmio_we", mmio_we, 0);
      tick();

      // Half load, zero-extended, upper lane
      issue(1'b1, 2'b01, 1'b1, 32'h0000_0102, 32'h0);
      chk("ldh_be", mem_be, 4'b1100);
      chk("ldh_addr", mem_addr, 32'h0000_0100);
      mem_ack = 1'b1; mem_rdata = 32'hBEEF_0000;
      tick();
      mem_ack = 1'b0;
      chk("ldh_done", done, 1);
      chk("ldh_rdata", rdata, 32'h0000_BEEF);
      tick();

      // Half load, sign-extended, lower lane
      issue(1'b1, 2'b01, 1'b0, 32'h0000_0100, 32'h0);
      chk("ldhs_be", mem_be, 4'b0011);
      mem_ack = 1'b1; mem_rdata = 32'h7777_8001;
      tick();
      mem_ack = 1'b0;
      chk("ldhs_rdata", rdata, 32'hFFFF_8001);
      tick();

      // Misaligned word load: error in 2 cycles, flag sticky
      issue(1'b1, 2'b10, 1'b0, 32'h0000_0101, 32'h0);
      chk("mis_req", mem_req, 0);
      chk("mis_done", done, 1);
      chk("mis_err", err_align, 1);
      tick();
      chk("mis_done_end", done, 0);
      chk("mis_sticky", err_align, 1);

      // Next valid start clears the flag; word load
      issue(1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'h0);
      chk("ldw_clr_err", err_align, 0);
      chk("ldw_be", mem_be, 4'b1111);
      chk("ldw_addr", mem_addr, 32'h0000_0104);
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      tick();
      mem_ack = 1'b0;
      chk("ldw_rdata", rdata, 32'hCAFE_F00D);
      tick();

      // Double access on a 32-bit datapath is illegal
      issue(1'b1, 2'b11, 1'b0, 32'h0000_0100, 32'h0);
      chk("dbl_done", done, 1);
      chk("dbl_err", err_align, 1);
      chk("dbl_req", mem_req, 0);
      tick();

      // Half store with 4 wait cycles; start while busy is ignored
      issue(1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_1234);
      chk("sth_we", mem_we, 1);
      chk("sth_be", mem_be, 4'b1100);
      chk("sth_wdata_hi", mem_wdata[31:16], 16'h1234);
      chk("sth_addr", mem_addr, 32'h0000_0200);
      chk("sth_err_clr", err_align, 0);
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin
            start = 1'b1; addr = 32'h0000_0400; op_load = 1'b1;
         end
         tick();
         start = 1'b0;
         chk("sth_wait_req", mem_req, 1);
         chk("sth_wait_addr", mem_addr, 32'h0000_0200);
         chk("sth_wait_done", done, 0);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("sth_done", done, 1);
      chk("sth_err_align", err_align, 0);
      chk("sth_err_timeout", err_timeout, 0);
      chk("sth_rdata", rdata, 0);
      tick();
      chk("sth_busy_end", busy, 0);

      // Byte store into lane 3
      issue(1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0000_00AB);
      chk("stb_be", mem_be, 4'b1000);
      chk("stb_wdata", mem_wdata[31:24], 8'hAB);
      chk("stb_we", mem_we, 1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("stb_done", done, 1);
      tick();

      // MMIO store: one strobe, done 3 cycles after start
      issue(1'b0, 2'b10, 1'b0, 32'h0007_0010, 32'h0000_0041);
      chk("mmst_we", mmio_we, 1);
      chk("mmst_addr", mmio_addr, 13'h0010);
      chk("mmst_wdata", mmio_wdata, 32'h41);
      chk("mmst_no_req", mem_req, 0);
      chk("mmst_no_done", done, 0);
      tick();
      chk("mmst_we_end", mmio_we, 0);
      chk("mmst_done", done, 1);
      chk("mmst_no_req2", mem_req, 0);
      tick();
      chk("mmst_done_end", done, 0);

      // Stray ack while idle is ignored
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("stray_done", done, 0);
      chk("stray_busy", busy, 0);

      // Watchdog expiry on the TIMEOUT=4 instance
      issue(1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
      for (int i = 0; i < 4; i++) begin
         chk("to_req_held", t_mem_req, 1);
         tick();
      end
      chk("to_req_drop", t_mem_req, 0);
      chk("to_done", t_done, 1);
      chk("to_err_timeout", t_err_timeout, 1);
      chk("to_err_align", t_err_align, 0);
      chk("to_main_still_req", mem_req, 1);
      mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
      tick();
      mem_ack = 1'b0;
      chk("to_main_done", done, 1);
      chk("to_main_no_to", err_timeout, 0);
      chk("to_sticky", t_err_timeout, 1);
      tick();

      // Ack in the same cycle the watchdog expires counts as success
      issue(1'b1, 2'b10, 1'b0, 32'h0000_0304, 32'h0);
      tick();
      tick();
      tick();
      chk("race_req", t_mem_req, 1);
      mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
      tick();
      mem_ack = 1'b0;
      chk("race_done", t_done, 1);
      chk("race_no_to", t_err_timeout, 0);
      chk("race_rdata", t_rdata, 32'h1111_2222);
      tick();

      // Reset during RAM_REQ aborts immediately
      issue(1'b1, 2'b10, 1'b0, 32'h0000_0308, 32'h0);
      chk("rmid_req", mem_req, 1);
      rst = 1'b0;
      #1;
      chk("rmid_busy", busy, 0);
      chk("rmid_req_drop", mem_req, 0);
      chk("rmid_done", done, 0);
      rst = 1'b1;
      tick();
      chk("rmid_no_done", done, 0);
      chk("rmid_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
